// File: rtl/instr_data_arbiter_if.sv
// instr_data_arbiter_if: instruction, data and RAM buses of the instruction/data arbiter
interface instr_data_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [15:0] conflict_cnt_o;
  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           mem_rvalid_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, conflict_cnt_o
  );
  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           mem_rvalid_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, conflict_cnt_o
  );
endinterface

// File: rtl/instr_data_arbiter.sv
// instr_data_arbiter: round-robin sharing of one single-port RAM between instruction and data ports
module instr_data_arbiter #(
  parameter logic [31:0] MemBase = 32'h0000_0000,
  parameter logic [31:0] MemSize = 32'h0001_0000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  instr_data_arbiter_if.slave bus
);
  logic        r_last_data;
  logic        r_resp_valid;
  logic        r_resp_data;
  logic        r_resp_err;
  logic [15:0] r_conflict_cnt;
  logic        w_both;
  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_acc;
  logic        w_in_range;
  logic        w_rv;
  logic        w_rv_i;
  logic        w_rv_d;
  logic [31:0] w_addr;
  logic [31:0] w_offset;
  always_comb begin
    w_both     = bus.instr_req_i && bus.data_req_i;
    w_gnt_d    = !rst_i && bus.data_req_i && (!bus.instr_req_i || !r_last_data);
    w_gnt_i    = !rst_i && bus.instr_req_i && (!bus.data_req_i || r_last_data);
    w_acc      = w_gnt_i || w_gnt_d;
    w_addr     = w_gnt_d ? bus.data_addr_i : bus.instr_addr_i;
    // unsigned wrap makes one compare cover both range bounds
    w_offset   = w_addr - MemBase;
    w_in_range = w_offset < MemSize;
    w_rv       = !rst_i && r_resp_valid && (r_resp_err || bus.mem_rvalid_i);
    w_rv_i     = w_rv && !r_resp_data;
    w_rv_d     = w_rv && r_resp_data;
  end
  assign bus.instr_gnt_o    = w_gnt_i;
  assign bus.data_gnt_o     = w_gnt_d;
  assign bus.mem_req_o      = w_acc && w_in_range;
  assign bus.mem_we_o       = w_gnt_d && bus.data_we_i;
  assign bus.mem_be_o       = w_gnt_d ? bus.data_be_i : (w_gnt_i ? 4'hF : 4'h0);
  assign bus.mem_addr_o     = w_acc ? w_offset : 32'h0;
  assign bus.mem_wdata_o    = w_gnt_d ? bus.data_wdata_i : 32'h0;
  assign bus.instr_rvalid_o = w_rv_i;
  assign bus.instr_err_o    = w_rv_i && r_resp_err;
  assign bus.instr_rdata_o  = (w_rv_i && !r_resp_err) ? bus.mem_rdata_i : 32'h0;
  assign bus.data_rvalid_o  = w_rv_d;
  assign bus.data_err_o     = w_rv_d && r_resp_err;
  assign bus.data_rdata_o   = (w_rv_d && !r_resp_err) ? bus.mem_rdata_i : 32'h0;
  assign bus.conflict_cnt_o = r_conflict_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_data    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 1'b0;
      r_resp_err     <= 1'b0;
      r_conflict_cnt <= 16'h0;
    end else begin
      if (w_acc) r_last_data <= w_gnt_d;
      r_resp_valid <= w_acc;
      r_resp_data  <= w_gnt_d;
      r_resp_err   <= !w_in_range;
      if (w_both && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_data_arbiter.sv
// tb_instr_data_arbiter: random and directed checks of the arbiter against a transaction-level model
module tb_instr_data_arbiter;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  instr_data_arbiter_if bus ();
  instr_data_arbiter #(.MemBase(BASE), .MemSize(SIZE)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] emu_ram [logic [31:0]];
  logic [31:0] model_ram [logic [31:0]];
  logic        emu_pend = 1'b0;
  logic [31:0] emu_data = 32'h0;
  int          m_last = 0;
  int          m_cnt = 0;
  logic        m_pv = 1'b0, m_pd = 1'b0, m_pin = 1'b0;
  logic [31:0] m_pdata = 32'h0;
  logic        e_ig, e_dg, e_in, e_mreq, e_irv, e_drv;
  logic [31:0] e_addr;
  logic        o_ig, o_dg, o_mreq, o_mwe, o_irv, o_ierr, o_drv, o_derr;
  logic [3:0]  o_mbe;
  logic [31:0] o_maddr, o_mwdata, o_ird, o_drd;
  logic [15:0] o_cnt;
  logic [155:0] obs_v, exp_v;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_ram.exists(a) ? model_ram[a] : init_word(a);
  endfunction
  function automatic logic [31:0] emu_rd(input logic [31:0] a);
    return emu_ram.exists(a) ? emu_ram[a] : init_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b+:8] = {8{be[b]}};
    return (old & ~m) | (wd & m);
  endfunction
  function automatic logic in_range(input logic [31:0] a);
    longint unsigned la, lb, ls;
    la = a;
    lb = BASE;
    ls = SIZE;
    return la >= lb && la < lb + ls;
  endfunction
  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return BASE + 32'($urandom_range(0, 63)) * 4;
    if (r == 8) return $urandom_range(0, 1) ? BASE + SIZE - 4 : BASE + SIZE;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic idle();
    bus.instr_req_i = 1'b0; bus.instr_addr_i = 32'h0;
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_i = 4'h0;
    bus.data_addr_i = 32'h0; bus.data_wdata_i = 32'h0;
  endtask
  task automatic rand_stim(input int pct);
    bus.instr_req_i = $urandom_range(0, 99) < pct;
    bus.instr_addr_i = rand_addr();
    bus.data_req_i = $urandom_range(0, 99) < pct;
    bus.data_we_i = 1'($urandom_range(0, 1));
    bus.data_be_i = 4'($urandom);
    bus.data_addr_i = rand_addr();
    bus.data_wdata_i = $urandom;
  endtask

  // one clock: RAM responder drives last cycle's answer, model predicts, outputs are captured
  task automatic tick();
    bus.mem_rvalid_i = emu_pend | 1'($urandom_range(0, 1));
    bus.mem_rdata_i = emu_pend ? emu_data : $urandom;
    #1;
    e_ig = !rst && bus.instr_req_i && (!bus.data_req_i || m_last == 1);
    e_dg = !rst && bus.data_req_i && !e_ig;
    e_addr = e_dg ? bus.data_addr_i : bus.instr_addr_i;
    e_in = in_range(e_addr);
    e_mreq = (e_ig || e_dg) && e_in;
    e_irv = !rst && m_pv && !m_pd;
    e_drv = !rst && m_pv && m_pd;
    exp_v = {e_ig, e_dg, e_mreq,
             e_mreq ? {e_dg && bus.data_we_i, e_dg ? bus.data_be_i : 4'hF, e_addr - BASE,
                       e_dg ? bus.data_wdata_i : 32'h0} : 69'h0,
             e_irv, e_irv && !m_pin, (e_irv && m_pin) ? m_pdata : 32'h0,
             e_drv, e_drv && !m_pin, (e_drv && m_pin) ? m_pdata : 32'h0, 16'(m_cnt)};
    o_ig = bus.instr_gnt_o; o_dg = bus.data_gnt_o; o_mreq = bus.mem_req_o; o_mwe = bus.mem_we_o;
    o_mbe = bus.mem_be_o; o_maddr = bus.mem_addr_o; o_mwdata = bus.mem_wdata_o;
    o_irv = bus.instr_rvalid_o; o_ierr = bus.instr_err_o; o_ird = bus.instr_rdata_o;
    o_drv = bus.data_rvalid_o; o_derr = bus.data_err_o; o_drd = bus.data_rdata_o;
    o_cnt = bus.conflict_cnt_o;
    obs_v = {o_ig, o_dg, o_mreq, (e_mreq || rst) ? {o_mwe, o_mbe, o_maddr, o_mwdata} : 69'h0,
             o_irv, o_ierr, o_ird, o_drv, o_derr, o_drd, o_cnt};
    @(posedge clk);
    emu_pend = o_mreq;
    if (o_mreq) begin
      emu_data = emu_rd(o_maddr + BASE);
      if (o_mwe) emu_ram[o_maddr + BASE] = merge(emu_data, o_mwdata, o_mbe);
    end
    if (rst) begin
      m_last = 0; m_cnt = 0; m_pv = 1'b0;
    end else begin
      if (bus.instr_req_i && bus.data_req_i && m_cnt < 65535) m_cnt++;
      m_pv = e_ig || e_dg;
      if (m_pv) begin
        m_last = e_dg ? 1 : 0;
        m_pd = e_dg;
        m_pin = e_in;
        m_pdata = model_rd(e_addr);
        if (e_dg && bus.data_we_i && e_in) model_ram[e_addr] = merge(m_pdata, bus.data_wdata_i, bus.data_be_i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_stim(100);
      tick();
      n_vec++;
      if ({o_ig, o_dg, o_mreq, o_mwe, o_mbe, o_maddr, o_mwdata, o_irv, o_ierr, o_drv, o_derr} !== 76'h0) begin
        n_err++;
        $display("FAIL reset_outputs: got gnt=%b%b mreq=%b we=%b be=%h addr=%h wd=%h rv=%b%b err=%b%b want all 0",
                 o_ig, o_dg, o_mreq, o_mwe, o_mbe, o_maddr, o_mwdata, o_irv, o_drv, o_ierr, o_derr);
      end
    end
    rst = 1'b0;
    idle();
    tick();
    n_vec++;
    if (o_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", o_cnt); end
  endtask

  task automatic test_instr_burst();
    logic [31:0] want;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k < 3) begin bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'(4 * k); end
      tick();
      if (k < 3) begin
        n_vec++;
        if ({o_ig, o_dg, o_mreq, o_mwe, o_mbe, o_maddr} !== {4'b1010, 4'hF, 32'(4 * k)}) begin
          n_err++;
          $display("FAIL burst_req%0d: got gnt=%b%b mreq=%b we=%b be=%h addr=%h want 1 0 1 0 f %h",
                   k, o_ig, o_dg, o_mreq, o_mwe, o_mbe, o_maddr, 32'(4 * k));
        end
      end
      if (k > 0) begin
        want = init_word(32'(4 * (k - 1)));
        n_vec++;
        if ({o_irv, o_ierr, o_ird, o_drv} !== {2'b10, want, 1'b0}) begin
          n_err++;
          $display("FAIL burst_resp%0d: got rv=%b err=%b rdata=%h drv=%b want 1 0 %h 0", k, o_irv, o_ierr, o_ird, o_drv, want);
        end
      end
    end
  endtask

  task automatic test_conflict();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h20;
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h24;
      tick();
      n_vec++;
      if ({o_ig, o_dg} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL conflict_gnt%0d: got i/d=%b%b want %s", k, o_ig, o_dg, (k % 2 == 0) ? "01" : "10");
      end
    end
    idle();
    tick();
    n_vec++;
    if (o_cnt !== 16'd4) begin n_err++; $display("FAIL conflict_cnt: got %0d want 4", o_cnt); end
  endtask

  task automatic test_write();
    logic [31:0] lo;
    idle();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h100; bus.data_wdata_i = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if ({o_dg, o_mreq, o_mwe, o_mbe, o_mwdata, o_maddr} !== {3'b111, 4'b0011, 32'hDEAD_BEEF, 32'h100}) begin
      n_err++;
      $display("FAIL write_req: got gnt=%b mreq=%b we=%b be=%b wd=%h addr=%h want 1 1 1 0011 deadbeef 100",
               o_dg, o_mreq, o_mwe, o_mbe, o_mwdata, o_maddr);
    end
    idle();
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h100;
    tick();
    n_vec++;
    if ({o_drv, o_derr, o_irv} !== 3'b100) begin
      n_err++;
      $display("FAIL write_resp: got rv=%b err=%b irv=%b want 1 0 0", o_drv, o_derr, o_irv);
    end
    idle();
    tick();
    lo = init_word(32'h100);
    n_vec++;
    if ({o_drv, o_drd} !== {1'b1, lo[31:16], 16'hBEEF}) begin
      n_err++;
      $display("FAIL write_readback: got rv=%b rdata=%h want 1 %h", o_drv, o_drd, {lo[31:16], 16'hBEEF});
    end
  endtask

  task automatic test_out_of_range();
    idle();
    bus.data_req_i = 1'b1; bus.data_addr_i = BASE + SIZE;
    tick();
    n_vec++;
    if ({o_dg, o_mreq} !== 2'b10) begin
      n_err++;
      $display("FAIL oor_req: got gnt=%b mreq=%b want 1 0", o_dg, o_mreq);
    end
    idle();
    tick();
    n_vec++;
    if ({o_drv, o_derr, o_drd, o_irv} !== {2'b11, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL oor_resp: got rv=%b err=%b rdata=%h irv=%b want 1 1 0 0", o_drv, o_derr, o_drd, o_irv);
    end
  endtask

  task automatic test_reset_drop();
    idle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h40;
    tick();
    n_vec++;
    if (o_ig !== 1'b1) begin n_err++; $display("FAIL drop_gnt: got %b want 1", o_ig); end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({o_irv, o_drv} !== 2'b00) begin n_err++; $display("FAIL drop_during_rst: got rv=%b%b want 00", o_irv, o_drv); end
    tick();
    n_vec++;
    if ({o_irv, o_drv, o_cnt} !== 18'h0) begin
      n_err++;
      $display("FAIL drop_after_rst: got rv=%b%b cnt=%h want 00 0000", o_irv, o_drv, o_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(0, 99) == 0;
      rand_stim(70);
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL random%0d: got %h want %h", k, obs_v, exp_v); end
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 65540; k++) begin
      bus.instr_req_i = 1'b1; bus.instr_addr_i = BASE + 32'($urandom_range(0, 15)) * 4;
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = BASE + 32'($urandom_range(0, 15)) * 4;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL saturate%0d: got %h want %h", k, obs_v, exp_v); end
    end
    idle();
    tick();
    n_vec++;
    if (o_cnt !== 16'hFFFF) begin n_err++; $display("FAIL saturate_cnt: got %h want ffff", o_cnt); end
  endtask

  initial begin
    idle();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_instr_burst();
    test_conflict();
    test_write();
    test_out_of_range();
    test_reset_drop();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
